uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that serializes one fixed-length word
// per grant, MSB byte first, onto a valid/ready byte stream for the UART TX.
// Optional macro UART_ARB_HDR_EN prepends a header byte {4'hA, winner} to
// every packet. Without it, packets carry payload bytes only.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BYTES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8*BYTES-1:0] req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [7:0]                 tx_byte,
    output logic                       tx_valid,
    input  logic                       tx_ready
);

    localparam int W     = 8 * BYTES;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
`ifdef UART_ARB_HDR_EN
        ST_DONE = 2'd2,
        ST_HDR  = 2'd3
`else
        ST_DONE = 2'd2
`endif
    } state_t;

`ifdef UART_ARB_HDR_EN
    localparam state_t ST_FIRST = ST_HDR;
`else
    localparam state_t ST_FIRST = ST_SEND;
`endif

    state_t             state_r, next_state_s;
    logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]   winner_r, winner_nxt_s;
    logic [W-1:0]       shift_r, shift_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               xfer_s;
    logic [NUM_REQ-1:0] grant_s, ack_s;
    logic               busy_s, tx_valid_s;
    logic [7:0]         tx_byte_s;

    // (base + off) mod NUM_REQ for requester indices
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    // one-hot vector with bit idx set
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign xfer_s = tx_valid & tx_ready;

    // round-robin pick: first requesting index at or above the pointer
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found_s && req[rr_wrap(ptr_r, i)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = rr_wrap(ptr_r, i);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state decode; the transfer handshake is the only thing that advances bytes
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    next_state_s = ST_FIRST;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                if (xfer_s) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_HDR;
                end
            end
`endif
            ST_SEND: begin
                if (xfer_s && (cnt_r == LAST_CNT)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // datapath next values: word capture at grant, byte shift on transfer, pointer advance
    always_comb begin
        shift_nxt_s  = shift_r;
        cnt_nxt_s    = cnt_r;
        winner_nxt_s = winner_r;
        ptr_nxt_s    = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    winner_nxt_s = pick_idx_s;
                    shift_nxt_s  = req_data[pick_idx_s*W +: W];
                    cnt_nxt_s    = '0;
                end else begin
                    cnt_nxt_s    = cnt_r;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    shift_nxt_s = shift_r << 4'd8;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    shift_nxt_s = shift_r;
                end
            end
            ST_DONE: ptr_nxt_s = rr_wrap(winner_r, 1);
            default: shift_nxt_s = shift_r;
        endcase
    end

    // output values for the coming cycle, derived from the next state
    always_comb begin
        busy_s     = (next_state_s != ST_IDLE);
`ifdef UART_ARB_HDR_EN
        tx_valid_s = (next_state_s == ST_SEND) || (next_state_s == ST_HDR);
`else
        tx_valid_s = (next_state_s == ST_SEND);
`endif
        grant_s    = tx_valid_s ? onehot(winner_nxt_s) : '0;
        ack_s      = (next_state_s == ST_DONE) ? onehot(winner_r) : '0;
        case (next_state_s)
            ST_SEND: tx_byte_s = shift_nxt_s[W-1 -: 8];
`ifdef UART_ARB_HDR_EN
            ST_HDR:  tx_byte_s = {4'hA, 4'(winner_nxt_s)};
`endif
            default: tx_byte_s = 8'h00;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r    <= '0;
            winner_r <= '0;
            shift_r  <= '0;
            cnt_r    <= '0;
            grant    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            ptr_r    <= ptr_nxt_s;
            winner_r <= winner_nxt_s;
            shift_r  <= shift_nxt_s;
            cnt_r    <= cnt_nxt_s;
            grant    <= grant_s;
            ack      <= ack_s;
            busy     <= busy_s;
            tx_valid <= tx_valid_s;
            tx_byte  <= tx_byte_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected bytes/grants and acks are
// queued as stimulus is applied and checked by a negedge monitor.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BYTES   = 2;
    localparam int W       = 8 * BYTES;
`ifdef UART_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*W-1:0]   req_data;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     ack;
    logic                   busy;
    logic [7:0]             tx_byte;
    logic                   tx_valid;
    logic                   tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];
    logic [3:0]  ack_q[$];
    logic [11:0] mon_e;
    logic [3:0]  mon_a;
    int g_cnt, b_cnt, lat;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BYTES(BYTES)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .busy     (busy),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] w);
        req_data[idx*W +: W] = w;
    endtask

    task automatic push_packet(input int idx, input logic [W-1:0] w);
        logic [3:0] i4;
        i4 = 4'(idx);
        if (HDR == 1) exp_q.push_back({i4, 4'hA, i4});
        for (int k = 0; k < BYTES; k++) exp_q.push_back({i4, w[W-1-8*k -: 8]});
        ack_q.push_back(i4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},    32'(grant),    32'd0);
        check({tag, "_ack"},      32'(ack),      32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_byte"},  32'(tx_byte),  32'd0);
    endtask

    // counts grant/busy cycles until ack[idx], bounded; returns just after the following edge
    task automatic wait_ack(input int idx, output int g, output int b, output int l);
        bit found;
        found = 1'b0;
        g = 0; b = 0; l = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            l++;
            if (grant[idx]) g++;
            if (busy) b++;
            if (ack[idx]) found = 1'b1;
        end
        check("ack_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every accepted byte and every ack pulse must be the next one expected
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            check("sb_byte_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("tx_byte", 32'(tx_byte), 32'(mon_e[7:0]));
                check("grant_at_byte", 32'(grant), 32'd1 << mon_e[11:8]);
            end
        end
        if (!reset && ack != '0) begin
            check("sb_ack_pending", 32'(ack_q.size() > 0), 32'd1);
            if (ack_q.size() > 0) begin
                mon_a = ack_q.pop_front();
                check("ack_onehot", 32'(ack), 32'd1 << mon_a);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // single requester, word changed after grant must not matter
        tx_ready = 1'b1;
        set_word(0, 16'hBEEF);
        push_packet(0, 16'hBEEF);
        req = 4'b0001;
        @(posedge clk);
        #1 set_word(0, 16'h0000);
        wait_ack(0, g_cnt, b_cnt, lat);
        req = 4'b0000;
        check("t1_grant_cycles", 32'(g_cnt), 32'(BYTES + HDR));
        check("t1_busy_cycles",  32'(b_cnt), 32'(BYTES + HDR + 1));
        check("t1_ack_latency",  32'(lat),   32'(BYTES + HDR + 1));
        check("t1_sb_empty",     32'(exp_q.size()), 32'd0);

        // reset pulse in idle brings pointer back to 0, then round-robin with all requesting
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        set_word(0, 16'h1111);
        set_word(1, 16'h2222);
        set_word(2, 16'h3333);
        set_word(3, 16'h4444);
        push_packet(0, 16'h1111);
        push_packet(1, 16'h2222);
        push_packet(2, 16'h3333);
        push_packet(3, 16'h4444);
        push_packet(0, 16'h1111);
        req = 4'b1111;
        wait_ack(0, g_cnt, b_cnt, lat);
        wait_ack(1, g_cnt, b_cnt, lat);
        wait_ack(2, g_cnt, b_cnt, lat);
        wait_ack(3, g_cnt, b_cnt, lat);
        wait_ack(0, g_cnt, b_cnt, lat);
        req = 4'b0000;
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // backpressure on the first payload byte
        tx_ready = 1'b0;
        set_word(0, 16'hBEEF);
        push_packet(0, 16'hBEEF);
        req = 4'b0001;
        @(posedge clk);
        #1;
        if (HDR == 1) begin
            tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_tx_valid", 32'(tx_valid), 32'd1);
            check("bp_tx_byte",  32'(tx_byte),  32'hBE);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_ack(0, g_cnt, b_cnt, lat);
        req = 4'b0000;
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // fairness: req[2] held, req[1] rises mid-transfer -> 2, 1, 2
        set_word(2, 16'h5A5A);
        set_word(1, 16'h1C1C);
        push_packet(2, 16'h5A5A);
        push_packet(1, 16'h1C1C);
        push_packet(2, 16'h5A5A);
        req = 4'b0100;
        @(posedge clk);
        #1 req = 4'b0110;
        wait_ack(2, g_cnt, b_cnt, lat);
        wait_ack(1, g_cnt, b_cnt, lat);
        req = 4'b0100;
        wait_ack(2, g_cnt, b_cnt, lat);
        req = 4'b0000;
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset after the first payload byte: abort, no ack, pointer back to 0
        set_word(0, 16'hBEEF);
        if (HDR == 1) exp_q.push_back({4'd0, 8'hA0});
        exp_q.push_back({4'd0, 8'hBE});
        req = 4'b0001;
        repeat (2 + HDR) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        check("t5_sb_partial_sent", 32'(exp_q.size()), 32'd0);
        set_word(3, 16'hCAFE);
        req = 4'b1001;
        @(posedge clk);
        #1 reset = 1'b0;
        push_packet(0, 16'hBEEF);
        push_packet(3, 16'hCAFE);
        wait_ack(0, g_cnt, b_cnt, lat);
        req = 4'b1000;
        wait_ack(3, g_cnt, b_cnt, lat);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_busy",         32'(busy),             32'd0);
        check("end_sb_empty",     32'(exp_q.size()),     32'd0);
        check("end_ack_q_empty",  32'(ack_q.size()),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
